// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the multi-cycle MIPS core.
//
// Owns the PC and drives the asynchronous instruction ROM's word address.
// It captures the returned word into an IF->ID buffer and hands that buffer
// to decode over a valid/allowin handshake. It also counts delivered
// instructions.
//
// Handshake: an instruction moves into decode on a rising edge where
// if_valid=1 and id_allowin=1. if_valid never drops without such an edge
// unless a redirect (exc_valid / jbr_taken) or reset kills the buffer.
//
// Optional feature macro: FETCH_ADDR_CHECK_EN.
//   Defined:   a misaligned or beyond-ROM fetch sets if_fault and delivers
//              a nop (0) in place of the ROM word.
//   Undefined: if_fault is tied low.
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   ROM_DEPTH  number of implemented 32-bit ROM words (1..256)
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   inst_addr     ROM word address (pc[9:2])
//   inst          ROM data for inst_addr
//   id_allowin    decode can accept this cycle
//   jbr_taken     branch/jump redirect pulse, target on jbr_target
//   exc_valid     exception/eret redirect pulse, target on exc_pc
//   if_valid      buffer holds a deliverable instruction
//   if_pc         PC of the buffered instruction
//   if_inst       buffered instruction word
//   if_fault      buffered instruction had a fetch address fault
//   fetch_cnt     number of instructions handed to decode
//   dbg_state     current FSM state (0 IDLE, 1 FETCH, 2 HOLD)

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_DEPTH = 110
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [7:0]  inst_addr,
  input  logic [31:0] inst,
  input  logic        id_allowin,
  input  logic        jbr_taken,
  input  logic [31:0] jbr_target,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_fault,
  output logic [31:0] fetch_cnt,
  output logic [1:0]  dbg_state
);

  // The ROM address port is 8 bits wide, so no more than 256 words exist.
  if (ROM_DEPTH < 1 || ROM_DEPTH > 256) begin : g_bad_rom_depth
    $error("fetch_unit: ROM_DEPTH must be in 1..256");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        handshake;
  logic        capture;
  logic        fetch_fault;

  // Exception/eret outranks branch/jump.
  assign redirect    = exc_valid | jbr_taken;
  assign redirect_pc = exc_valid ? exc_pc : jbr_target;

  // The buffer is only ever valid in HOLD; the state term keeps the
  // handshake tied to the FSM.
  assign handshake = (state_q == S_HOLD) & valid_q & id_allowin;

  // A redirect during FETCH kills the fetch in progress, so nothing is
  // captured on that edge.
  assign capture = (state_q == S_FETCH) & ~redirect;

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [31:0] ROM_WORDS = 32'(ROM_DEPTH);
  assign fetch_fault = (pc_q[1:0] != 2'b00) | ({2'b00, pc_q[31:2]} >= ROM_WORDS);
`else
  assign fetch_fault = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: state_d = S_HOLD;
        S_HOLD:  if (handshake) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    pc_d      = pc_q;
    valid_d   = valid_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;

    if (capture) begin
      if_pc_d   = pc_q;
      if_inst_d = fetch_fault ? 32'h0000_0000 : inst;
      fault_d   = fetch_fault;
      valid_d   = 1'b1;
    end

    // Decode has consumed the buffer on a handshake edge, so it is counted
    // even when a redirect arrives in the same cycle.
    if (handshake) begin
      cnt_d   = cnt_q + 32'd1;
      pc_d    = pc_q + 32'd4;
      valid_d = 1'b0;
    end

    // Redirect overrides the sequential PC and kills whatever is buffered.
    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      if_pc_q   <= 32'h0000_0000;
      if_inst_q <= 32'h0000_0000;
      fault_q   <= 1'b0;
      cnt_q     <= 32'h0000_0000;
    end else begin
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end

  assign inst_addr = pc_q[9:2];
  assign if_valid  = valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_fault  = fault_q;
  assign fetch_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule
